booth_seq_mult: RTL

BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

---
 rtl/booth_seq_mult.sv | 104 ++++++++++
 1 files changed

// File: rtl/booth_seq_mult.sv
// rtl/booth_seq_mult.sv - radix-2 Booth sequential multiplier, signed or unsigned operands
// One Booth step per CALC cycle over WIDTH+1 extended bits, so latency is fixed at WIDTH+1 cycles.
module booth_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t             r_state;
  // Accumulator carries one guard bit beyond the extended operand so add/subtract never overflows.
  logic [WIDTH+1:0]   r_acc;
  logic [WIDTH+1:0]   r_mcand;
  logic [WIDTH:0]     r_q;
  logic               r_q_m1;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH+1:0]   w_a_ext;
  logic [WIDTH:0]     w_b_ext;
  logic [WIDTH+1:0]   w_sum;
  logic [WIDTH+1:0]   w_acc_next;
  logic [WIDTH:0]     w_q_next;

  always_comb begin
    w_a_ext = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    w_b_ext = signed_mode ? {b[WIDTH-1], b} : {1'b0, b};
  end

  always_comb begin
    w_sum = r_acc;
    case ({r_q[0], r_q_m1})
      2'b01:   w_sum = r_acc + r_mcand;
      2'b10:   w_sum = r_acc - r_mcand;
      default: w_sum = r_acc;
    endcase
    w_acc_next = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
    w_q_next   = {w_sum[0], r_q[WIDTH:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_mcand <= '0;
      r_q     <= '0;
      r_q_m1  <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      p       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_mcand <= w_a_ext;
            r_acc   <= '0;
            r_q     <= w_b_ext;
            r_q_m1  <= 1'b0;
            r_cnt   <= CW'(WIDTH + 1);
            busy    <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc  <= w_acc_next;
          r_q    <= w_q_next;
          r_q_m1 <= r_q[0];
          r_cnt  <= r_cnt - 1'b1;
          // Last step: publish the product straight from the step result.
          if (r_cnt == CW'(1)) begin
            p       <= {w_acc_next[WIDTH-2:0], w_q_next};
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
